painel_scan_ctrl: RTL and testbench

- Row-scan sequencer for the 5-column x 7-row LED dot-matrix panel.
- Accepts a 35-bit bitmap over a valid/ready handshake into a pending buffer; promotes it to the displayed frame only at a frame boundary, so no tearing.
- Cycles the 3-bit row select (sel1..sel3) at a programmable rate and drives the one-hot row enable plus 5 column bits for the current row.
- Sits upstream of the column demultiplexer bank; drives its shared select lines.

---
 rtl/painel_pkg.sv | 31 +++
 rtl/painel_scan_ctrl_if.sv | 22 ++
 rtl/painel_row_timer.sv | 44 ++++
 rtl/painel_scan_ctrl.sv | 142 ++++++++++++++
 tb/tb_painel_scan_ctrl.sv | 229 ++++++++++++++++++++++
 5 files changed

// File: rtl/painel_pkg.sv
// Shared definitions for the 5x7 LED panel scan controller.
// Geometry, FSM encoding and bitmap indexing helpers.
package painel_pkg;

   localparam int ROWS    = 7;
   localparam int COLS    = 5;
   localparam int FRAME_W = ROWS * COLS;

   typedef enum logic [1:0] {
      IDLE,
      BLANK,
      SHOW
   } state_t;

   function automatic logic [5:0] bitIdx(input int col, input int row);
      return 6'(col * ROWS + row);
   endfunction

   function automatic logic [COLS-1:0] rowBits(
      input logic [FRAME_W-1:0] frame,
      input logic [2:0]         row
   );
      logic [COLS-1:0] bits;
      bits = '0;
      for (int c = 0; c < COLS; c++) begin
         bits[c] = frame[bitIdx(c, int'(row))];
      end
      return bits;
   endfunction

endpackage

// File: rtl/painel_scan_ctrl_if.sv
// Bitmap transfer handshake between the frame producer
// and the panel scan controller.
interface painel_scan_ctrl_if;
   import painel_pkg::*;

   logic               frame_valid;
   logic [FRAME_W-1:0] frame_data;
   logic               frame_ready;

   modport master (
      output frame_valid,
      output frame_data,
      input  frame_ready
   );

   modport slave (
      input  frame_valid,
      input  frame_data,
      output frame_ready
   );

endinterface

// File: rtl/painel_row_timer.sv
// Row slot divider: counts clocks inside one row slot and
// flags the slot end and the leading blank window.
module painel_row_timer #(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic clk,
   input  logic rst_n,
   input  logic run,
   output logic rowTick,
   output logic blankActive
);

   localparam int DW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
   localparam logic [DW-1:0] LAST = DW'(CLK_DIV - 1);
   localparam logic [DW-1:0] BLK  = DW'(BLANK_CYCLES);

   logic [DW-1:0] cnt;
   logic [DW-1:0] cntNext;

   // Next count: parked at zero while idle, wraps at slot end.
   always_comb begin
      cntNext = cnt;
      if (!run || cnt == LAST) begin
         cntNext = '0;
      end else begin
         cntNext = cnt + DW'(1);
      end
   end

   // blankActive describes the cycle that follows the next edge.
   assign rowTick     = run && (cnt == LAST);
   assign blankActive = cntNext < BLK;

   // Divider register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt <= '0;
      end else begin
         cnt <= cntNext;
      end
   end

endmodule

// File: rtl/painel_scan_ctrl.sv
// Row-scan sequencer for the 5x7 LED dot-matrix panel with
// tear-free frame promotion at the row 6 -> 0 boundary.
module painel_scan_ctrl
   import painel_pkg::*;
#(
   parameter int CLK_DIV      = 50000,
   parameter int BLANK_CYCLES = 2
) (
   input  logic             clk,
   input  logic             rst_n,
   painel_scan_ctrl_if.slave frm,
   output logic             sel1,
   output logic             sel2,
   output logic             sel3,
   output logic [ROWS-1:0]  row_en,
   output logic [COLS-1:0]  col_data,
   output logic             frame_start
);

   localparam logic [2:0] LASTROW = 3'(ROWS - 1);

   state_t             state;
   state_t             stateNext;
   logic [2:0]         row;
   logic [2:0]         rowNext;
   logic [FRAME_W-1:0] active;
   logic [FRAME_W-1:0] activeNext;
   logic [FRAME_W-1:0] pending;
   logic [FRAME_W-1:0] pendingNext;
   logic               pendingFull;
   logic               pendingFullNext;
   logic               startNext;
   logic               readyQ;
   logic               accept;
   logic               rowTick;
   logic               blankActive;

   logic [2:0]         selQ;
   logic [ROWS-1:0]    rowEnQ;
   logic [COLS-1:0]    colQ;
   logic               startQ;

   painel_row_timer #(
      .CLK_DIV      (CLK_DIV),
      .BLANK_CYCLES (BLANK_CYCLES)
   ) u_timer (
      .clk         (clk),
      .rst_n       (rst_n),
      .run         (state != IDLE),
      .rowTick     (rowTick),
      .blankActive (blankActive)
   );

   assign accept = frm.frame_valid & readyQ;

   // Next state, row, buffers and frame-start strobe.
   always_comb begin
      stateNext       = state;
      rowNext         = row;
      activeNext      = active;
      pendingNext     = pending;
      pendingFullNext = pendingFull;
      startNext       = 1'b0;
      unique case (state)
         IDLE: begin
            if (accept) begin
               activeNext = frm.frame_data;
               stateNext  = blankActive ? BLANK : SHOW;
               rowNext    = '0;
               startNext  = 1'b1;
            end
         end
         BLANK, SHOW: begin
            stateNext = blankActive ? BLANK : SHOW;
            if (rowTick) begin
               if (row == LASTROW) begin
                  rowNext   = '0;
                  startNext = 1'b1;
                  if (pendingFull) begin
                     activeNext      = pending;
                     pendingFullNext = 1'b0;
                  end
               end else begin
                  rowNext = row + 3'd1;
               end
            end
            // A frame landing on the promotion edge refills pending.
            if (accept) begin
               pendingNext     = frm.frame_data;
               pendingFullNext = 1'b1;
            end
         end
         default: begin
            stateNext = IDLE;
         end
      endcase
   end

   // State, row and frame buffer registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         row         <= '0;
         active      <= '0;
         pending     <= '0;
         pendingFull <= 1'b0;
      end else begin
         state       <= stateNext;
         row         <= rowNext;
         active      <= activeNext;
         pending     <= pendingNext;
         pendingFull <= pendingFullNext;
      end
   end

   // Output registers, loaded from next-state values so they
   // line up with the state they describe.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         selQ   <= '0;
         rowEnQ <= '0;
         colQ   <= '0;
         startQ <= 1'b0;
         readyQ <= 1'b1;
      end else begin
         selQ   <= rowNext;
         rowEnQ <= (stateNext == SHOW) ? (ROWS'(1) << rowNext) : '0;
         colQ   <= (stateNext == IDLE) ? '0 : rowBits(activeNext, rowNext);
         startQ <= startNext;
         readyQ <= ~pendingFullNext;
      end
   end

   assign sel1            = selQ[0];
   assign sel2            = selQ[1];
   assign sel3            = selQ[2];
   assign row_en          = rowEnQ;
   assign col_data        = colQ;
   assign frame_start     = startQ;
   assign frm.frame_ready = readyQ;

endmodule

// File: tb/tb_painel_scan_ctrl.sv
// Bench for painel_scan_ctrl: directed steps plus random frames,
// checked every cycle against a time-based display model.
module tb_painel_scan_ctrl;
   import painel_pkg::*;

   localparam int DIV = 8;
   localparam int BLK = 2;
   localparam int FR  = DIV * ROWS;

   logic            clk = 1'b0;
   logic            rst_n;
   logic            sel1;
   logic            sel2;
   logic            sel3;
   logic [ROWS-1:0] row_en;
   logic [COLS-1:0] col_data;
   logic            frame_start;

   painel_scan_ctrl_if bus();

   painel_scan_ctrl #(
      .CLK_DIV      (DIV),
      .BLANK_CYCLES (BLK)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .frm         (bus),
      .sel1        (sel1),
      .sel2        (sel2),
      .sel3        (sel3),
      .row_en      (row_en),
      .col_data    (col_data),
      .frame_start (frame_start)
   );

   always #5 clk = ~clk;

   int checks   = 0;
   int failures = 0;

   // Model: t counts cycles since the first frame started.
   logic [FRAME_W-1:0] mAct;
   logic [FRAME_W-1:0] mPend;
   bit                 mFull;
   bit                 mRun;
   int                 t;

   function automatic logic [FRAME_W-1:0] rand35();
      logic [63:0] x;
      x = {$urandom(), $urandom()};
      return x[FRAME_W-1:0];
   endfunction

   function automatic int curRow();
      return (t / DIV) % ROWS;
   endfunction

   function automatic logic [16:0] expVal();
      int              r;
      logic [ROWS-1:0] re;
      logic [COLS-1:0] cd;
      logic [FRAME_W-1:0] sh;
      if (!mRun) return {1'b1, 16'b0};
      r  = curRow();
      re = ((t % DIV) < BLK) ? '0 : (ROWS'(1) << r);
      cd = '0;
      for (int c = 0; c < COLS; c++) begin
         sh    = mAct >> (c * ROWS + r);
         cd[c] = sh[0];
      end
      return {!mFull, (t % FR) == 0, 3'(r), re, cd};
   endfunction

   task automatic check(input string tag);
      logic [16:0] o;
      logic [16:0] e;
      o = {bus.frame_ready, frame_start, sel3, sel2, sel1,
           row_en, col_data};
      e = expVal();
      checks++;
      assert (o === e) else begin
         failures++;
         $error("FAIL %s t=%0t obs=%h exp=%h", tag, $time, o, e);
      end
   endtask

   task automatic modelReset();
      mRun  = 0;
      mFull = 0;
      mAct  = '0;
      mPend = '0;
      t     = 0;
   endtask

   task automatic step(input string tag);
      bit acc;
      @(posedge clk);
      acc = 0;
      if (!rst_n) begin
         modelReset();
      end else begin
         acc = bus.frame_valid && !mFull;
         if (!mRun) begin
            if (acc) begin
               mRun = 1;
               t    = 0;
               mAct = bus.frame_data;
            end
         end else begin
            t++;
            if ((t % FR) == 0 && mFull) begin
               mAct  = mPend;
               mFull = 0;
            end
            if (acc) begin
               mPend = bus.frame_data;
               mFull = 1;
            end
         end
      end
      #1 check(tag);
      if (acc) bus.frame_valid = 1'b0;
   endtask

   task automatic run(input int n, input string tag);
      for (int i = 0; i < n; i++) step(tag);
   endtask

   // Producer holds valid until the frame is taken.
   task automatic offer(input logic [FRAME_W-1:0] d, input string tag);
      bus.frame_valid = 1'b1;
      bus.frame_data  = d;
      for (int i = 0; i < 200 && bus.frame_valid; i++) step(tag);
      checks++;
      assert (!bus.frame_valid) else begin
         failures++;
         $error("FAIL %s accept timeout obs=valid exp=accepted", tag);
         bus.frame_valid = 1'b0;
      end
   endtask

   task automatic waitRow(input int r, input bit show, input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (mRun && curRow() == r && (!show || (t % DIV) >= BLK)) begin
            ok = 1;
            break;
         end
         step(tag);
      end
      checks++;
      assert (ok) else begin
         failures++;
         $error("FAIL %s wait timeout obs=row%0d exp=row%0d", tag,
                curRow(), r);
      end
   endtask

   task automatic waitPromo(input string tag);
      bit ok;
      ok = 0;
      for (int i = 0; i < 200; i++) begin
         if (mRun && (t % FR) == FR - 1) begin
            ok = 1;
            break;
         end
         step(tag);
      end
      checks++;
      assert (ok) else begin
         failures++;
         $error("FAIL %s wait timeout obs=%0d exp=%0d", tag, t % FR, FR - 1);
      end
   endtask

   initial begin
      logic [FRAME_W-1:0] cb;
      modelReset();
      rst_n           = 1'b0;
      bus.frame_valid = 1'b1;
      bus.frame_data  = rand35();
      run(3, "reset");

      bus.frame_valid = 1'b0;
      rst_n           = 1'b1;
      run(3, "idle");

      offer('1, "first");
      run(FR + 4, "frame1");

      for (int c = 0; c < COLS; c++)
         for (int r = 0; r < ROWS; r++)
            cb[c * ROWS + r] = 1'((c + r) & 1);
      offer(cb, "checker_acc");
      waitRow(0, 0, "checker_wait0");
      waitRow(3, 1, "checker_row3");
      run(4, "checker_run");

      waitRow(2, 0, "second_row2");
      offer(rand35(), "second");
      waitPromo("third_wait");
      offer(rand35(), "third");
      run(FR + 8, "after_third");

      for (int i = 0; i < 300; i++) begin
         if (!bus.frame_valid && $urandom_range(0, 9) == 0) begin
            bus.frame_valid = 1'b1;
            bus.frame_data  = rand35();
         end
         step("random");
      end
      bus.frame_valid = 1'b0;

      waitRow(4, 1, "async_row4");
      #2 rst_n = 1'b0;
      modelReset();
      #1 check("async_rst");
      run(2, "in_rst");
      rst_n = 1'b1;
      run(5, "post_rst_idle");
      offer(rand35(), "restart");
      run(20, "restart_run");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
